// File: rtl/serdes_pkg.sv
// serdes_pkg: shared types, counter-width helper and idle-level default for the serial link blocks
package serdes_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic IDLE_LEVEL_DEF = 1'b0;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake, bit strobe and serial output bundle
interface piso_serializer_if #(parameter int DATA_W = 8);
  logic load_valid;
  logic load_ready;
  logic [DATA_W-1:0] load_data;
  logic bit_en;
  logic ser_out;
  logic ser_valid;
  logic ser_last;
  logic done;
  modport master (output load_valid, load_data, bit_en, input load_ready, ser_out, ser_valid, ser_last, done);
  modport slave (input load_valid, load_data, bit_en, output load_ready, ser_out, ser_valid, ser_last, done);
endinterface

// File: rtl/piso_hold_buf.sv
// piso_hold_buf: one-entry word buffer with full flag
module piso_hold_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              unload,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      full <= 1'b0;
    end else begin
      if (load) dout <= din;
      full <= load ? 1'b1 : unload ? 1'b0 : full;
    end
  end
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out transmitter with a one-word holding buffer
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter bit   LSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input logic clk,
  input logic rst_n,
  piso_serializer_if.slave bus
);
  localparam int CNT_W = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [DATA_W-1:0] sh, sh_nx, buf_data;
  logic buf_full, done_q, accept, eow, buf_load, buf_unload;
  assign accept     = bus.load_valid && !buf_full;
  assign eow        = state == SHIFT && bus.bit_en && cnt == LAST;
  assign buf_unload = eow && buf_full;
  // at end of word an empty buffer is bypassed so the new word starts with no gap
  assign buf_load   = state == SHIFT && accept && !eow;
  piso_hold_buf #(.DATA_W(DATA_W)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .load(buf_load),
    .unload(buf_unload),
    .din(bus.load_data),
    .dout(buf_data),
    .full(buf_full)
  );
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sh_nx    = sh;
    if (state == IDLE && accept) begin
      state_nx = SHIFT;
      cnt_nx   = '0;
      sh_nx    = bus.load_data;
    end else if (eow) begin
      state_nx = (buf_full || accept) ? SHIFT : IDLE;
      cnt_nx   = '0;
      sh_nx    = buf_full ? buf_data : bus.load_data;
    end else if (state == SHIFT && bus.bit_en) begin
      cnt_nx = cnt + 1'b1;
      sh_nx  = LSB_FIRST ? sh >> 1 : sh << 1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sh     <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      sh     <= sh_nx;
      done_q <= eow;
    end
  end
  assign bus.load_ready = !buf_full;
  assign bus.ser_valid  = state == SHIFT;
  assign bus.ser_out    = state == SHIFT ? (LSB_FIRST ? sh[0] : sh[DATA_W-1]) : IDLE_LEVEL;
  assign bus.ser_last   = state == SHIFT && cnt == LAST;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of an LSB-first and an MSB-first serializer driven in lockstep
module tb_piso_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_valid = 1'b0;
  logic bit_en = 1'b0;
  logic [7:0] load_data = '0;
  logic [7:0] w;
  logic [23:0] stream;
  logic [7:0] words [3];
  int checks = 0;
  int errors = 0;
  int widx;
  bit acc;
  piso_serializer_if #(8) bl ();
  piso_serializer_if #(8) bm ();
  assign bl.load_valid = load_valid;
  assign bl.load_data  = load_data;
  assign bl.bit_en     = bit_en;
  assign bm.load_valid = load_valid;
  assign bm.load_data  = load_data;
  assign bm.bit_en     = bit_en;
  piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(bl));
  piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst_n(rst_n), .bus(bm));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_word(input logic [7:0] v);
    load_data  = v;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_bit", bl.ser_out, v[i]);
      chk("msb_bit", bm.ser_out, v[7-i]);
      chk("valid", bl.ser_valid, 1);
      chk("last", bl.ser_last, i == 7);
      chk("msb_last", bm.ser_last, i == 7);
      chk("done_low", bl.done, 0);
      step();
    end
    chk("done", bl.done, 1);
    chk("msb_done", bm.done, 1);
    chk("end_valid", bl.ser_valid, 0);
    chk("end_out", bl.ser_out, 0);
    step();
    chk("done_once", bl.done, 0);
  endtask
  initial begin
    #1;
    chk("rst_out", bl.ser_out, 0);
    chk("rst_valid", bl.ser_valid, 0);
    chk("rst_last", bl.ser_last, 0);
    chk("rst_done", bl.done, 0);
    chk("rst_ready", bl.load_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    step();
    bit_en = 1'b1;
    run_word(8'hA5);
    run_word(8'h0F);
    stream[15:0] = {8'hC3, 8'h3C};
    load_data  = 8'h3C;
    load_valid = 1'b1;
    step();
    load_data = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_bit", bl.ser_out, stream[i]);
      chk("b2b_valid", bl.ser_valid, 1);
      chk("b2b_last", bl.ser_last, i == 7 || i == 15);
      chk("b2b_done", bl.done, i == 8);
      step();
      load_valid = 1'b0;
    end
    chk("b2b_done_end", bl.done, 1);
    chk("b2b_valid_end", bl.ser_valid, 0);
    step();
    w          = 8'h81;
    bit_en     = 1'b0;
    load_data  = w;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      bit_en = (c % 3 == 0);
      chk("slow_lsb", bl.ser_out, w[(c-1)/3]);
      chk("slow_msb", bm.ser_out, w[7-(c-1)/3]);
      chk("slow_valid", bl.ser_valid, 1);
      chk("slow_done", bl.done, 0);
      step();
    end
    chk("slow_done_end", bl.done, 1);
    chk("slow_valid_end", bl.ser_valid, 0);
    bit_en = 1'b1;
    step();
    words  = '{8'h11, 8'h22, 8'h33};
    stream = {8'h33, 8'h22, 8'h11};
    widx   = 0;
    for (int c = 0; c <= 24; c++) begin
      load_valid = widx < 3;
      if (widx < 3) load_data = words[widx];
      chk("q_ready", bl.load_ready, c <= 1 || c == 9 || c >= 17);
      chk("q_valid", bl.ser_valid, c >= 1);
      if (c >= 1) begin
        chk("q_bit", bl.ser_out, stream[c-1]);
        chk("q_done", bl.done, c == 9 || c == 17);
        chk("q_last", bl.ser_last, c == 8 || c == 16 || c == 24);
      end
      acc = load_valid && bl.load_ready;
      step();
      if (acc) widx++;
    end
    load_valid = 1'b0;
    chk("q_done_end", bl.done, 1);
    chk("q_valid_end", bl.ser_valid, 0);
    chk("q_accepted", widx, 3);
    step();
    load_data  = 8'hFF;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    step();
    step();
    chk("mid_valid", bl.ser_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bl.ser_valid, 0);
    chk("arst_out", bl.ser_out, 0);
    chk("arst_last", bl.ser_last, 0);
    chk("arst_ready", bl.load_ready, 1);
    chk("arst_msb_valid", bm.ser_valid, 0);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_valid", bl.ser_valid, 0);
    chk("post_rst_out", bl.ser_out, 0);
    chk("post_rst_done", bl.done, 0);
    run_word(8'h01);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
